// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Time-multiplexed scan controller for an N_DIGITS common-anode 7-segment
//   display. A packed hex value and its masks are captured once per frame.
//   Each digit is then given a fixed slot: a blanking gap with every anode
//   off, followed by the lit period. A digit that is disabled keeps its slot
//   but stays dark, so the frame length, and with it the brightness, does not
//   depend on the mask.
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   value      : packed hex digits, digit i = value[4*i+3:4*i]
//   en_mask    : 1 = digit i displayed
//   dp_mask    : 1 = decimal point lit on digit i
//   digit      : nibble for the segment decoder
//   anode      : active-low digit enables (at most one low)
//   dp         : active-low decimal point
//   frame_done : one-cycle pulse on the first cycle after a frame ends
module display_scan_controller #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   en_mask,
  input  logic [N_DIGITS-1:0]   dp_mask,
  output logic [3:0]            digit,
  output logic [N_DIGITS-1:0]   anode,
  output logic                  dp,
  output logic                  frame_done
);

  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                state, state_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [4*N_DIGITS-1:0] value_q, value_n;
  logic [N_DIGITS-1:0]   en_q, en_n;
  logic [N_DIGITS-1:0]   dp_q, dp_n;
  logic [3:0]            digit_n;
  logic [N_DIGITS-1:0]   anode_n;
  logic                  dpo_n;
  logic                  frame_done_n;

  // Next-state logic. Outputs are derived from the *next* state, index and
  // shadow values so the registered outputs change on the same edge as the
  // state they describe.
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    cnt_n        = cnt + CNT_W'(1);
    value_n      = value_q;
    en_n         = en_q;
    dp_n         = dp_q;
    frame_done_n = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (|en_mask) begin
          value_n = value;
          en_n    = en_mask;
          dp_n    = dp_mask;
          idx_n   = '0;
          state_n = BLANK;
        end
      end
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          cnt_n   = '0;
          state_n = SHOW;
        end
      end
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_n = '0;
          if (idx == IDX_LAST) begin
            frame_done_n = 1'b1;
            idx_n        = '0;
            if (|en_mask) begin
              value_n = value;
              en_n    = en_mask;
              dp_n    = dp_mask;
              state_n = BLANK;
            end else begin
              state_n = IDLE;
            end
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = BLANK;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase

    anode_n = '1;
    dpo_n   = 1'b1;
    digit_n = '0;
    if (state_n == BLANK) begin
      digit_n = value_n[4*idx_n +: 4];
    end else if (state_n == SHOW) begin
      digit_n        = value_n[4*idx_n +: 4];
      anode_n[idx_n] = ~en_n[idx_n];
      dpo_n          = ~(dp_n[idx_n] & en_n[idx_n]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      cnt        <= '0;
      value_q    <= '0;
      en_q       <= '0;
      dp_q       <= '0;
      digit      <= '0;
      anode      <= '1;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      cnt        <= cnt_n;
      value_q    <= value_n;
      en_q       <= en_n;
      dp_q       <= dp_n;
      digit      <= digit_n;
      anode      <= anode_n;
      dp         <= dpo_n;
      frame_done <= frame_done_n;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
//   Directed bench for display_scan_controller with N_DIGITS=8,
//   REFRESH_DIV=4, BLANK_CYCLES=2 (6-cycle slots, 48-cycle frames).
//   Expected per-cycle outputs {frame_done, anode, digit, dp} are queued
//   as each frame is scheduled and popped one per clock.
module tb_display_scan_controller;

  logic        clk;
  logic        rst;
  logic [31:0] value;
  logic [7:0]  en_mask;
  logic [7:0]  dp_mask;
  logic [3:0]  digit;
  logic [7:0]  anode;
  logic        dp;
  logic        frame_done;

  int vectors;
  int miscompares;
  logic [13:0] expq[$];

  display_scan_controller #(
    .N_DIGITS(8),
    .REFRESH_DIV(4),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(rst),
    .value(value),
    .en_mask(en_mask),
    .dp_mask(dp_mask),
    .digit(digit),
    .anode(anode),
    .dp(dp),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] mk(input logic fd, input logic [7:0] an,
                                     input logic [3:0] dg, input logic d);
    return {fd, an, dg, d};
  endfunction

  function automatic logic [13:0] observed();
    return {frame_done, anode, digit, dp};
  endfunction

  task automatic check(input string tag, input logic [13:0] exp);
    logic [13:0] obs;
    obs = observed();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s t=%0t: got fd/anode/digit/dp=%h expected %h", tag, $time, obs, exp);
    end
  endtask

  // One full frame: for each digit, 2 blank cycles then 4 lit cycles.
  task automatic push_frame(input logic [31:0] v, input logic [7:0] en,
                            input logic [7:0] dpm, input logic fd_first);
    logic [3:0] nib;
    logic [7:0] an;
    for (int i = 0; i < 8; i++) begin
      nib = v[4*i +: 4];
      an  = 8'hFF;
      an[i] = ~en[i];
      for (int j = 0; j < 2; j++)
        expq.push_back(mk((i == 0 && j == 0) ? fd_first : 1'b0, 8'hFF, nib, 1'b1));
      for (int j = 0; j < 4; j++)
        expq.push_back(mk(1'b0, an, nib, ~(dpm[i] & en[i])));
    end
  endtask

  task automatic run(input int n, input string tag);
    logic [13:0] exp;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL %s: scoreboard empty, got %h expected a queued vector", tag, observed());
      end else begin
        exp = expq.pop_front();
        check(tag, exp);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b1;
    value   = 32'h89ABCDEF;
    en_mask = 8'hFF;
    dp_mask = 8'h00;

    #1 check("reset", mk(1'b0, 8'hFF, 4'h0, 1'b1));
    #1 rst = 1'b0;
    #1 check("idle_after_reset", mk(1'b0, 8'hFF, 4'h0, 1'b1));

    // Full frame, all digits lit
    push_frame(32'h89ABCDEF, 8'hFF, 8'h00, 1'b0);
    run(48, "frame_all");

    // Only digit 0 enabled; value changed during slot 3 must not tear
    en_mask = 8'h01;
    push_frame(32'h89ABCDEF, 8'h01, 8'h00, 1'b1);
    run(20, "frame_en01");
    value = 32'h0;
    run(28, "frame_en01_tear");

    // New frame picks up zeroed value; decimal point on digit 2 only
    en_mask = 8'hFF;
    dp_mask = 8'h04;
    push_frame(32'h0, 8'hFF, 8'h04, 1'b1);
    run(48, "frame_dp");

    // en_mask cleared during slot 5: frame completes, then IDLE
    value   = 32'h89ABCDEF;
    dp_mask = 8'h00;
    push_frame(32'h89ABCDEF, 8'hFF, 8'h00, 1'b1);
    run(32, "frame_stop");
    en_mask = 8'h00;
    run(16, "frame_stop_tail");
    expq.push_back(mk(1'b1, 8'hFF, 4'h0, 1'b1));
    expq.push_back(mk(1'b0, 8'hFF, 4'h0, 1'b1));
    expq.push_back(mk(1'b0, 8'hFF, 4'h0, 1'b1));
    run(3, "idle");

    // Restart from IDLE, then reset asynchronously while digit 2 is lit
    en_mask = 8'hFF;
    push_frame(32'h89ABCDEF, 8'hFF, 8'h00, 1'b0);
    run(15, "restart");
    #2 rst = 1'b1;
    #1 check("async_reset", mk(1'b0, 8'hFF, 4'h0, 1'b1));
    expq.delete();
    @(posedge clk);
    #1 check("held_reset", mk(1'b0, 8'hFF, 4'h0, 1'b1));
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
